mux_n_to_1_rr: RTL and testbench
================================

# mux_n_to_1_rr

Parametrised, registered N-to-1 multiplexer with a valid/ready handshake on every input channel and on the output. It extends the fixed 4:1 combinational select into a round-robin arbiter with one output register stage. It sits wherever several producers share one consumer of the same data width. An optional compile-time feature restores direct channel selection, as in the older combinational mux.

## Interface
- WIDTH, 4: data width per channel, ≥1.
- CHANNELS, 4: number of input channels, 2..16. Need not be a power of two.
- SEL_W, derived localparam: max(1, clog2(CHANNELS)). Not overridable.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready, at most one bit high.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_sel  output  SEL_W  source channel index of the word in the output register.

## Operation
- Transfer rules:
  - An input transfer on channel k occurs when in_valid[k] && in_ready[k].
  - An output transfer occurs when out_valid && out_ready.
- Load enable:
  - load = !out_valid || out_ready.
  - The output register accepts a new word only when load is high.
- Arbitration:
  - A pointer ptr (SEL_W bits) names the highest-priority channel.
  - The search runs ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1.
  - The first channel with in_valid high is the grant g.
  - in_ready[g] = load. All other in_ready bits are 0.
  - With no valid channel, in_ready is all-zero.
- On an input transfer from channel g:
  - out_data ← channel g data, out_sel ← g, out_valid ← 1.
  - ptr ← g+1, wrapping from CHANNELS-1 to 0.
- Output transfer with no input transfer in the same cycle: out_valid ← 0. out_data and out_sel hold their values.
- Simultaneous output and input transfer: the register is reloaded and out_valid stays 1. This gives full throughput of one word per cycle.
- ptr changes only on an input transfer. An idle cycle or a stalled output never moves it.
- Fairness: with all channels continuously valid and out_ready held at 1, the grants cycle 0,1,…,CHANNELS-1,0,…
- The output is a one-state register (EMPTY/FULL, encoded by out_valid):
  - EMPTY→FULL on an input transfer.
  - FULL→EMPTY on an output transfer without an input transfer.
  - FULL→FULL when both transfers occur, or when out_ready is 0.
- Stall: while out_valid && !out_ready, out_data, out_sel and out_valid are held stable and in_ready is all-zero.

## Timing
- Reset values, asserted asynchronously:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready evaluates to 0 because of the reset gate.
- Release: state leaves reset on the first rising edge after rst deasserts.
- Reset mid-operation: the word in the output register is discarded. Arbitration restarts from channel 0.
- Latency: an input accepted at edge n appears on out_data/out_valid immediately after edge n (one register stage).
- Combinational paths:
  - in_valid, out_ready and ptr drive in_ready combinationally.
  - No combinational path exists from in_data or in_valid to out_data or out_valid.
- Producers must hold in_data and in_valid stable until their transfer occurs. The block does not check this.

## Configuration
- MUX_FORCE_SEL_EN defined:
  - Adds ports force_en (input, 1) and force_sel (input, SEL_W).
  - While force_en=1, only channel force_sel is eligible for grant. Round-robin is bypassed and ptr is not updated.
  - force_sel ≥ CHANNELS grants nothing.
  - When force_en returns to 0, round-robin resumes from the retained ptr.
- MUX_FORCE_SEL_EN undefined: the ports are absent and the block is pure round-robin.

## Test plan
All scenarios use WIDTH=4 and CHANNELS=4.
- Reset: assert rst mid-stream with out_valid=1 → out_valid, out_data and out_sel read 0 with no clock edge, and in_ready=0000.
- Full contention: all valid, data 0xA/0xB/0xC/0xD, out_ready=1 → out_sel sequence 0,1,2,3,0 with data A,B,C,D,A, out_valid continuously 1.
- Sparse requests: only channels 1 and 3 valid, ptr=2 → channel 3 granted first, then 1, then 3.
- Backpressure: out_ready=0 for 3 cycles with out_data=0x5 → out_data is held at 0x5, in_ready=0000, and ptr is unchanged. Raising out_ready gives the next grant in the same cycle.
- Non-power-of-two: CHANNELS=3, all valid → out_sel sequence 0,1,2,0 (wrap verified).
- With MUX_FORCE_SEL_EN: force_en=1, force_sel=2, all valid → only in_ready[2] pulses and out_sel=2 every cycle. Releasing force_en resumes the grant from the pre-force ptr.

Source files
------------

// File: rtl/mux_n_to_1_rr.sv
// Registered N-to-1 round-robin multiplexer with valid/ready on every channel and on the output.
// Optional MUX_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
//
// state | meaning
// EMPTY | output register holds no word (out_valid = 0)
// FULL  | output register holds a word from channel out_sel (out_valid = 1)
module mux_n_to_1_rr #(
    parameter int  WIDTH    = 4,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef MUX_FORCE_SEL_EN
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
`endif
    output logic [SEL_W-1:0]          out_sel
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_next;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_found;
    logic               rr_bypass;
    logic               load;
    logic               xfer_in;
    logic [WIDTH-1:0]   sel_data;
    int                 idx;

    assign out_valid = (state == FULL);
    assign load      = !out_valid || out_ready;
    assign xfer_in   = grant_found && load;

    // Search order ptr, ptr+1, ... wrapping at CHANNELS (not necessarily a power of two).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_bypass   = 1'b0;
        idx         = 0;
`ifdef MUX_FORCE_SEL_EN
        rr_bypass   = force_en;
`endif
        if (rr_bypass) begin
`ifdef MUX_FORCE_SEL_EN
            for (int j = 0; j < CHANNELS; j++) begin
                if (force_sel == SEL_W'(j) && in_valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(j);
                end
            end
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = int'(ptr) + i;
                if (idx >= CHANNELS)
                    idx = idx - CHANNELS;
                for (int j = 0; j < CHANNELS; j++) begin
                    if (!grant_found && idx == j && in_valid[j]) begin
                        grant_found = 1'b1;
                        grant_idx   = SEL_W'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant_idx == SEL_W'(j))
                sel_data = in_data[j*WIDTH +: WIDTH];
            // Gated by rst so in_ready drops the moment reset asserts.
            in_ready[j] = !rst && xfer_in && (grant_idx == SEL_W'(j));
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                EMPTY: if (xfer_in) state <= FULL;
                FULL:  if (out_ready && !xfer_in) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (xfer_in) begin
                out_data <= sel_data;
                out_sel  <= grant_idx;
                if (!rr_bypass)
                    ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Scoreboard bench for mux_n_to_1_rr: directed scenarios plus randomized traffic against a
// queue-based reference model; a second instance covers a non-power-of-two channel count.
module tb_mux_n_to_1_rr;

    localparam int W   = 4;
    localparam int CH  = 4;
    localparam int SEL = 2;
    localparam int CH3 = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH*W-1:0]   in_data = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SEL-1:0]    out_sel;

    logic [CH3*W-1:0]  in_data3 = '0;
    logic [CH3-1:0]    in_valid3 = '0;
    logic [CH3-1:0]    in_ready3;
    logic [W-1:0]      out_data3;
    logic              out_valid3;
    logic              out_ready3 = 1'b0;
    logic [SEL-1:0]    out_sel3;

`ifdef MUX_FORCE_SEL_EN
    logic              force_en = 1'b0;
    logic [SEL-1:0]    force_sel = '0;
    logic              force_en3 = 1'b0;
    logic [SEL-1:0]    force_sel3 = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int mptr = 0;
    int last_grant = -1;
    logic [W+SEL-1:0] sb_q[$];

    always #5 clk = ~clk;

    mux_n_to_1_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_FORCE_SEL_EN
        .force_en(force_en), .force_sel(force_sel),
`endif
        .out_sel(out_sel)
    );

    mux_n_to_1_rr #(.WIDTH(W), .CHANNELS(CH3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef MUX_FORCE_SEL_EN
        .force_en(force_en3), .force_sel(force_sel3),
`endif
        .out_sel(out_sel3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, predict grant from the rules, check in_ready,
    // and after the edge queue the word the output register must now hold.
    task automatic cycle(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic r);
        int  g;
        bit  load;
        bit  forced;
        logic [CH-1:0] exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        load   = (sb_q.size() == 0) || r;
        g      = -1;
        forced = 1'b0;
`ifdef MUX_FORCE_SEL_EN
        forced = force_en;
        if (forced && int'(force_sel) < CH && v[force_sel])
            g = int'(force_sel);
`endif
        if (!forced)
            for (int k = 0; k < CH; k++)
                if (g < 0 && v[(mptr + k) % CH])
                    g = (mptr + k) % CH;
        exp_ready = '0;
        if (g >= 0 && load)
            exp_ready[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        last_grant = (g >= 0 && load) ? g : -1;
        @(posedge clk);
        if (last_grant >= 0) begin
            sb_q.push_back({d[last_grant*W +: W], SEL'(last_grant)});
            if (!forced)
                mptr = (last_grant + 1) % CH;
        end
    endtask

    // Monitor: the queue mirrors the output register; a word is retired on an output transfer.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
                if (out_valid && sb_q.size() != 0) begin
                    chk("out_data", 32'(out_data), 32'(sb_q[0][W+SEL-1:SEL]));
                    chk("out_sel", 32'(out_sel), 32'(sb_q[0][SEL-1:0]));
                    if (out_ready)
                        void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [CH*W-1:0] abcd;
        logic [CH-1:0]   cur_v;
        logic [CH*W-1:0] cur_d;
        int              seq3[4];
        int              sparse_seq[3];

        abcd          = {4'hD, 4'hC, 4'hB, 4'hA};
        seq3          = '{0, 1, 2, 0};
        sparse_seq    = '{3, 1, 3};

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Three channels, all valid: grant order must wrap 2 -> 0.
        @(negedge clk);
        in_valid3  = 3'b111;
        in_data3   = {4'h3, 4'h2, 4'h1};
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("ch3_out_sel", 32'(out_sel3), 32'(seq3[i]));
            chk("ch3_out_data", 32'(out_data3), 32'(seq3[i] + 1));
            chk("ch3_out_valid", 32'(out_valid3), 32'd1);
        end
        in_valid3 = '0;

        // Full contention from ptr 0.
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, abcd, 1'b1);
            #1;
            chk("contend_sel", 32'(out_sel), 32'(i % CH));
            chk("contend_data", 32'(out_data), 32'(4'hA + 4'(i % CH)));
        end

        // Sparse: ptr is now 2, only channels 1 and 3 request.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, abcd, 1'b1);
            #1;
            chk("sparse_sel", 32'(out_sel), 32'(sparse_seq[i]));
        end

        // Backpressure: load 0x5 from channel 0, then stall with others requesting.
        cycle(4'b0001, {4'hD, 4'hC, 4'hB, 4'h5}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1110, abcd, 1'b0);
            #1;
            chk("stall_data", 32'(out_data), 32'h5);
            chk("stall_sel", 32'(out_sel), 32'd0);
        end
        cycle(4'b1110, abcd, 1'b1);
        #1;
        chk("unstall_sel", 32'(out_sel), 32'd1);
        chk("unstall_data", 32'(out_data), 32'hB);

        // Randomized traffic; producers hold valid/data until their transfer.
        cur_v = '0;
        cur_d = '0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++)
                if (!cur_v[c] && $urandom_range(1, 0) == 1) begin
                    cur_v[c]         = 1'b1;
                    cur_d[c*W +: W]  = W'($urandom);
                end
            cycle(cur_v, cur_d, $urandom_range(3, 0) != 0);
            if (last_grant >= 0)
                cur_v[last_grant] = 1'b0;
        end

        // Reset mid-stream with a word held in the register.
        cycle(4'b1111, abcd, 1'b0);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_sel", 32'(out_sel), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        mptr   = 0;
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, abcd, 1'b1);
            #1;
            chk("restart_sel", 32'(out_sel), 32'(i));
        end

`ifdef MUX_FORCE_SEL_EN
        // ptr is 3 here; forcing channel 2 must not disturb it.
        force_sel = 2'd2;
        force_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, abcd, 1'b1);
            #1;
            chk("force_sel", 32'(out_sel), 32'd2);
        end
        force_en = 1'b0;
        cycle(4'b1111, abcd, 1'b1);
        #1;
        chk("force_resume_sel", 32'(out_sel), 32'd3);

        @(negedge clk);
        force_sel3 = 2'd3;
        force_en3  = 1'b1;
        in_valid3  = 3'b111;
        #1;
        chk("force_oob_ready", 32'(in_ready3), 32'd0);
        force_en3 = 1'b0;
        in_valid3 = '0;
`endif

        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
